nexys_switch_led_ctrl: RTL and testbench
========================================

// Module: nexys_switch_led_ctrl
// PURPOSE
//   Parametrised board-I/O front end: WIDTH slide switches drive WIDTH LEDs through
//   per-input synchroniser + debouncer; one push button blanks the LEDs (debounced).
//   Adds freeze (hold) mode, button press pulse and switch-change pulse for downstream
//   control logic. Sits directly behind board pins, before any user logic.
// PARAMETERS
//   WIDTH            4      number of switch/LED channels (>=1)
//   SYNC_STAGES      2      flip-flops in each input synchroniser (>=2)
//   DEBOUNCE_CYCLES  100000 consecutive clk cycles an input must differ before accepted (>=1)
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   swt        in   WIDTH  raw switch pins, asynchronous to clk
//   btn        in   1      raw blank button, asynchronous to clk, active-high
//   hold       in   1      freeze request, synchronous to clk, level
//   led        out  WIDTH  LED drive, registered
//   btn_pulse  out  1      one-cycle pulse on debounced btn rising edge
//   swt_change out  1      one-cycle pulse when any debounced switch bit changes
// BEHAVIOUR
//   Reset (rst_n=0, async): all sync FFs, debounce counters, stable values, led,
//     btn_pulse, swt_change = 0. Reset mid-debounce discards partial counts.
//   Sync: each of WIDTH+1 inputs passes SYNC_STAGES FFs -> s.
//   Debounce per bit (cnt width $clog2(DEBOUNCE_CYCLES+1)):
//     s != stable: if cnt == DEBOUNCE_CYCLES-1 {stable<=s; cnt<=0} else cnt<=cnt+1
//     s == stable: cnt<=0  (any bounce back restarts the count)
//   LED register, priority order, each edge:
//     btn_db=1 -> led<=0 ; else hold=1 -> led<=led ; else led<=swt_db
//   Releasing hold: led follows swt_db on next edge. Releasing btn with hold=1:
//     led stays 0 until hold drops (frozen value is the blanked one).
//   Latency pin->led: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges, input held steady.
//   btn_pulse <= btn_db & ~btn_db_q (registered, 1 cycle late vs btn_db, one per press).
//   swt_change <= |(swt_db ^ swt_db_q); asserts regardless of hold/btn state.
//   Simultaneous changes on several switch bits in same cycle -> single pulse.
//   Bits debounce independently; bit updates never wait for other bits.
//   Glitch shorter than DEBOUNCE_CYCLES after sync: no effect on any output.
// STRUCTURE
//   Package nexys_io_pkg: DEBOUNCE_DEFAULT, SYNC_STAGES_DEFAULT constants,
//     LED_RESET value; elaboration-time parameter range checks as $error.
//   Sub-module input_debouncer (SYNC_STAGES, DEBOUNCE_CYCLES; clk, rst_n, din,
//     dout): synchroniser + counter for one bit, instantiated WIDTH+1 times
//     (generate loop for swt, one instance for btn).
//   Top holds led register, edge detectors, pulse outputs only.
// TESTING  (bench uses WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   1 Reset: rst_n=0 mid-clock with swt=4'hF -> led=0, pulses 0 immediately,
//     led still 0 until 2+4+1 edges after rst_n release with swt steady.
//   2 Latency: swt 0->4'hA steady -> led=4'hA exactly 7 edges later,
//     swt_change=1 for exactly one cycle.
//   3 Bounce: swt[0] toggles 1 for 3 cycles then back, repeated -> led[0] stays 0,
//     swt_change never asserts; then held 1 for 4+ cycles -> led[0]=1.
//   4 Blank: swt=4'hF, btn pressed steady -> led=0 after 7 edges, btn_pulse one
//     cycle; btn released -> led=4'hF after 7 edges, no btn_pulse on release.
//   5 Hold: led=4'h5, hold=1, swt->4'h3 -> led stays 4'h5, swt_change pulses;
//     hold=0 -> led=4'h3 next edge.
//   6 Priority: hold=1 and btn pressed -> led=0; btn released, hold still 1
//     -> led remains 0; hold=0 -> led=swt_db next edge.

Source files
------------

// File: rtl/nexys_io_pkg.sv
// Shared constants and parameter sanity check for the switch/LED board front end.
package nexys_io_pkg;

  localparam int   DEBOUNCE_DEFAULT    = 100000;
  localparam int   SYNC_STAGES_DEFAULT = 2;
  localparam logic LED_RESET           = 1'b0;

  function automatic bit params_ok(input int width, input int sync_stages,
                                   input int debounce_cycles);
    return (width >= 32'sd1) && (sync_stages >= 32'sd2) && (debounce_cycles >= 32'sd1);
  endfunction

endpackage

// File: rtl/nexys_switch_led_ctrl_if.sv
// Pin-side bundle of the switch/LED front end; slave modport is the controller's view.
interface nexys_switch_led_ctrl_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] swt_i;
  logic             btn_i;
  logic             hold_i;
  logic [WIDTH-1:0] led_o;
  logic             btn_pulse_o;
  logic             swt_change_o;

  modport master (
    output swt_i, btn_i, hold_i,
    input  led_o, btn_pulse_o, swt_change_o
  );

  modport slave (
    input  swt_i, btn_i, hold_i,
    output led_o, btn_pulse_o, swt_change_o
  );

endinterface

// File: rtl/input_debouncer.sv
// One asynchronous pin: multi-flop synchroniser followed by a consecutive-sample debouncer.
module input_debouncer
  import nexys_io_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (!params_ok(32'sd1, SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_err
    $error("input_debouncer: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_s;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  assign s_s = sync_q[SYNC_STAGES-1];

  // Any sample agreeing with the accepted value restarts the run count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s_s != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = s_s;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d    = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchroniser chain, run counter and accepted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{1'b0}};
      stable_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/nexys_switch_led_ctrl.sv
// Board I/O front end: debounced switches drive LEDs, with blank button, freeze and
// change/press pulses for downstream logic.
module nexys_switch_led_ctrl
  import nexys_io_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nexys_switch_led_ctrl_if.slave io
);

  if (!params_ok(WIDTH, SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_param_err
    $error("nexys_switch_led_ctrl: WIDTH >= 1, SYNC_STAGES >= 2, DEBOUNCE_CYCLES >= 1");
  end

  logic [WIDTH-1:0] swt_db_s;
  logic             btn_db_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_swt
    input_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_swt_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (io.swt_i[i]),
      .dout  (swt_db_s[i])
    );
  end

  input_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (io.btn_i),
    .dout  (btn_db_s)
  );

  logic [WIDTH-1:0] led_q, led_d;
  logic [WIDTH-1:0] swt_db_q;
  logic             btn_db_q;
  logic             btn_pulse_q, btn_pulse_d;
  logic             swt_change_q, swt_change_d;

  // Blanking beats freeze, so releasing the button under hold keeps the LEDs dark.
  always_comb begin
    if (btn_db_s) begin
      led_d = {WIDTH{1'b0}};
    end else if (io.hold_i) begin
      led_d = led_q;
    end else begin
      led_d = swt_db_s;
    end
    btn_pulse_d  = btn_db_s & ~btn_db_q;
    swt_change_d = |(swt_db_s ^ swt_db_q);
  end

  // Output registers and the delayed debounced copies used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q        <= {WIDTH{LED_RESET}};
      swt_db_q     <= {WIDTH{1'b0}};
      btn_db_q     <= 1'b0;
      btn_pulse_q  <= 1'b0;
      swt_change_q <= 1'b0;
    end else begin
      led_q        <= led_d;
      swt_db_q     <= swt_db_s;
      btn_db_q     <= btn_db_s;
      btn_pulse_q  <= btn_pulse_d;
      swt_change_q <= swt_change_d;
    end
  end

  assign io.led_o        = led_q;
  assign io.btn_pulse_o  = btn_pulse_q;
  assign io.swt_change_o = swt_change_q;

endmodule

// File: tb/tb_nexys_switch_led_ctrl.sv
// Self-checking bench: directed vector table plus randomized stimulus against a
// sample-window reference model of the switch/LED front end.
module tb_nexys_switch_led_ctrl;

  localparam int W   = 4;
  localparam int TS  = 2;
  localparam int TD  = 4;
  localparam int HL  = TS + TD;
  localparam int NCH = W + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nexys_switch_led_ctrl_if #(.WIDTH(W)) bus ();

  nexys_switch_led_ctrl #(
    .WIDTH           (W),
    .SYNC_STAGES     (TS),
    .DEBOUNCE_CYCLES (TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per channel, the last HL pin samples (index 0 = newest).
  // A value is accepted once the TD synchronised samples are all identical.
  bit         hist [NCH][HL];
  bit         m_stable [NCH];
  bit         m_prev [NCH];
  logic [W-1:0] m_led;
  bit         m_bp, m_sc;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int a = 0; a < HL; a++) hist[c][a] = 1'b0;
      m_stable[c] = 1'b0;
      m_prev[c]   = 1'b0;
    end
    m_led = '0;
    m_bp  = 1'b0;
    m_sc  = 1'b0;
  endfunction

  function automatic void model_edge(input logic [W-1:0] sw, input bit b, input bit h);
    logic [W-1:0] db_sw, prev_sw;
    bit pins [NCH];
    bit uni;
    for (int c = 0; c < W; c++) begin
      db_sw[c]   = m_stable[c];
      prev_sw[c] = m_prev[c];
      pins[c]    = sw[c];
    end
    pins[W] = b;
    if (m_stable[W])  m_led = '0;
    else if (!h)      m_led = db_sw;
    m_bp = m_stable[W] && !m_prev[W];
    m_sc = (db_sw != prev_sw);
    for (int c = 0; c < NCH; c++) m_prev[c] = m_stable[c];
    for (int c = 0; c < NCH; c++) begin
      for (int a = HL - 1; a > 0; a--) hist[c][a] = hist[c][a-1];
      hist[c][0] = pins[c];
      uni = 1'b1;
      for (int a = TS; a < HL; a++) if (hist[c][a] != hist[c][TS]) uni = 1'b0;
      if (uni) m_stable[c] = hist[c][TS];
    end
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [W-1:0] sw, input bit b, input bit h);
    bus.swt_i  = sw;
    bus.btn_i  = b;
    bus.hold_i = h;
    @(posedge clk);
    model_edge(sw, b, h);
    #1;
    chk("led", bus.led_o, m_led);
    chk("btn_pulse", W'(bus.btn_pulse_o), W'(m_bp));
    chk("swt_change", W'(bus.swt_change_o), W'(m_sc));
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_led", bus.led_o, 4'h0);
    chk("rst_btn_pulse", W'(bus.btn_pulse_o), 4'h0);
    chk("rst_swt_change", W'(bus.swt_change_o), 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] swt;
    bit           btn;
    bit           hold;
    int           n;
    logic [W-1:0] led;
    bit           bp;
    bit           sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [W-1:0] sw, input bit b, input bit h, input int n,
                     input logic [W-1:0] led, input bit bp, input bit sc);
    vec_t v;
    v.swt = sw; v.btn = b; v.hold = h; v.n = n; v.led = led; v.bp = bp; v.sc = sc;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset release with swt=F, then 0, then A: 7-edge latency and single change pulse
    add(4'hF,0,0,6, 4'h0,0,0); add(4'hF,0,0,1, 4'hF,0,1); add(4'hF,0,0,1, 4'hF,0,0);
    add(4'h0,0,0,6, 4'hF,0,0); add(4'h0,0,0,1, 4'h0,0,1); add(4'h0,0,0,1, 4'h0,0,0);
    add(4'hA,0,0,6, 4'h0,0,0); add(4'hA,0,0,1, 4'hA,0,1); add(4'hA,0,0,1, 4'hA,0,0);
    // Bounce on swt[0] shorter than the debounce window, then held
    add(4'hB,0,0,3, 4'hA,0,0); add(4'hA,0,0,3, 4'hA,0,0);
    add(4'hB,0,0,3, 4'hA,0,0); add(4'hA,0,0,3, 4'hA,0,0);
    add(4'hB,0,0,6, 4'hA,0,0); add(4'hB,0,0,1, 4'hB,0,1); add(4'hB,0,0,1, 4'hB,0,0);
    // Blank button press and release
    add(4'hF,0,0,6, 4'hB,0,0); add(4'hF,0,0,1, 4'hF,0,1); add(4'hF,0,0,1, 4'hF,0,0);
    add(4'hF,1,0,6, 4'hF,0,0); add(4'hF,1,0,1, 4'h0,1,0); add(4'hF,1,0,1, 4'h0,0,0);
    add(4'hF,0,0,6, 4'h0,0,0); add(4'hF,0,0,1, 4'hF,0,0); add(4'hF,0,0,1, 4'hF,0,0);
    // Hold freezes LEDs while change pulse still fires
    add(4'h5,0,0,6, 4'hF,0,0); add(4'h5,0,0,1, 4'h5,0,1); add(4'h5,0,0,1, 4'h5,0,0);
    add(4'h3,0,1,6, 4'h5,0,0); add(4'h3,0,1,1, 4'h5,0,1); add(4'h3,0,1,1, 4'h5,0,0);
    add(4'h3,0,0,1, 4'h3,0,0);
    // Blank over hold, release button under hold, then release hold
    add(4'h3,1,1,6, 4'h3,0,0); add(4'h3,1,1,1, 4'h0,1,0); add(4'h3,1,1,1, 4'h0,0,0);
    add(4'h3,0,1,8, 4'h0,0,0); add(4'h3,0,0,1, 4'h3,0,0);

    bus.swt_i  = '0;
    bus.btn_i  = 1'b0;
    bus.hold_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("por_led", bus.led_o, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step(4'hF, 1'b0, 1'b0);
    chk("pre_reset_led", bus.led_o, 4'hF);
    mid_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (vecs[i].n) step(vecs[i].swt, vecs[i].btn, vecs[i].hold);
      chk($sformatf("vec%0d_led", i), bus.led_o, vecs[i].led);
      chk($sformatf("vec%0d_btn_pulse", i), W'(bus.btn_pulse_o), W'(vecs[i].bp));
      chk($sformatf("vec%0d_swt_change", i), W'(bus.swt_change_o), W'(vecs[i].sc));
    end

    for (int k = 0; k < 300; k++) begin
      logic [W-1:0] sw;
      bit b, h;
      int n;
      sw = W'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) == 0);
      h  = ($urandom_range(0, 3) == 0);
      n  = $urandom_range(1, 9);
      repeat (n) step(sw, b, h);
      if ($urandom_range(0, 39) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
